// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared loader state encoding and NOP constant
package npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } ld_state_t;

    // Wide enough for any supported INST_WIDTH; users slice the low bits.
    localparam int NOP_MAX_WIDTH = 1024;
    localparam logic [NOP_MAX_WIDTH-1:0] NOP_WORD = '0;

endpackage

// File: rtl/npu_word_packer.sv
// rtl/npu_word_packer.sv - little-endian WPI-word instruction assembly register
module npu_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int WPI        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      load,
    input  logic [DATA_WIDTH-1:0]     word,
    output logic [DATA_WIDTH*WPI-1:0] data,
    output logic                      last,
    output logic                      full
);
    localparam int CW = $clog2(WPI + 1);

    logic [CW-1:0] cnt;

    // Shifting right leaves the first word in the lowest lane once WPI words are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            data <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            data <= {word, data[DATA_WIDTH*WPI-1:DATA_WIDTH]};
            cnt  <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(WPI - 1));
    assign full = (cnt == CW'(WPI));

endmodule

// File: rtl/npu_inst_loader.sv
// rtl/npu_inst_loader.sv - DDR-to-instruction-RAM loader; NPU_INST_LOADER_CHECKSUM_EN adds a word checksum
module npu_inst_loader
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 128,
    parameter int INST_AW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] load_base,
    input  logic [INST_AW:0]      load_max,
    output logic                  load_ready,
    output logic                  load_done,
    output logic [INST_AW:0]      load_count,
    output logic [DATA_WIDTH-1:0] load_checksum,
    output logic                  DDR_READ_CLK,
    output logic [DATA_WIDTH-1:0] DDR_READ_ADDR,
    output logic                  DDR_READ_REQ,
    input  logic                  DDR_READ_READY,
    input  logic [DATA_WIDTH-1:0] DDR_READ_DATA,
    input  logic                  DDR_READ_DATA_VALID,
    output logic                  npu_inst_wr_en,
    output logic [INST_AW-1:0]    npu_inst_wr_addr,
    output logic [INST_WIDTH-1:0] npu_inst_wr_data
);
    localparam int WPI = INST_WIDTH / DATA_WIDTH;
    localparam logic [INST_WIDTH-1:0] NOP = NOP_WORD[INST_WIDTH-1:0];

    ld_state_t             state;
    logic [DATA_WIDTH-1:0] rd_addr;
    logic [INST_AW-1:0]    inst_idx;
    logic [INST_AW:0]      count_r;
    logic [INST_AW:0]      max_r;
    logic [INST_AW:0]      next_count;
    logic                  req_r, wr_en_r, done_r, ready_r;
    logic                  start, capture, pk_clear, pk_last, pk_full;
    logic [INST_WIDTH-1:0] inst_data;

    assign start      = (state == ST_IDLE) && load_start;
    assign capture    = (state == ST_WAIT) && DDR_READ_DATA_VALID;
    assign pk_clear   = start || (state == ST_WRITE);
    assign next_count = count_r + (INST_AW+1)'(1);

    npu_word_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WPI        (WPI)
    ) u_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (pk_clear),
        .load  (capture),
        .word  (DDR_READ_DATA),
        .data  (inst_data),
        .last  (pk_last),
        .full  (pk_full)
    );

    // Outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_addr  <= '0;
            inst_idx <= '0;
            count_r  <= '0;
            max_r    <= '0;
            req_r    <= 1'b0;
            wr_en_r  <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            req_r   <= 1'b0;
            wr_en_r <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state    <= ST_REQ;
                        req_r    <= 1'b1;
                        rd_addr  <= load_base;
                        inst_idx <= '0;
                        count_r  <= '0;
                        max_r    <= (load_max == '0) ? (INST_AW+1)'(1 << INST_AW) : load_max;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (DDR_READ_READY) begin
                        state <= ST_WAIT;
                    end else begin
                        req_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (DDR_READ_DATA_VALID) begin
                        rd_addr <= rd_addr + DATA_WIDTH'(1);
                        if (pk_last) begin
                            state   <= ST_WRITE;
                            wr_en_r <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                            req_r <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    count_r  <= next_count;
                    inst_idx <= inst_idx + INST_AW'(1);
                    // A NOP is still written but ends the program.
                    if (inst_data == NOP || next_count == max_r) begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                    end else begin
                        state <= ST_REQ;
                        req_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef NPU_INST_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            checksum <= '0;
        end else if (capture) begin
            checksum <= checksum + DDR_READ_DATA;
        end
    end

    assign load_checksum = checksum;
`else
    assign load_checksum = '0;
`endif

    assign DDR_READ_CLK     = clk;
    assign DDR_READ_ADDR    = rd_addr;
    assign DDR_READ_REQ     = req_r;
    assign load_ready       = ready_r;
    assign load_done        = done_r;
    assign load_count       = count_r;
    assign npu_inst_wr_en   = wr_en_r & pk_full;
    assign npu_inst_wr_addr = inst_idx;
    assign npu_inst_wr_data = inst_data;

endmodule
